// File: rtl/ma_window_scheduler.sv
// ma_window_scheduler
// Sequences the price-window datapath. Prices arrive from the upstream feed on
// a valid/ready handshake. Each accepted price is written into the 10-deep
// price memory with a one-cycle strobe. Once the memory is full, every write
// also launches the moving-average FSM. The scheduler then waits for its done
// (with a timeout) and presents the result downstream as a one-cycle pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   in_valid     upstream price valid
//   in_price     upstream price
//   in_ready     scheduler can accept a price (decoded from state)
//   mem_we       one-cycle write strobe per accepted price
//   mem_wdata    price being written; held until the next accept
//   mem_count    memory fill count (checked only, never exceeds WINDOW)
//   mem_full     memory holds WINDOW prices
//   ma_start     one-cycle start pulse to the moving-average FSM
//   ma_done      moving-average FSM completion
//   ma_avg       moving-average result
//   avg_valid    one-cycle pulse, avg_out valid
//   avg_out      latched moving average
//   err_timeout  sticky: a computation timed out (cleared by reset only)
//   win_count    number of averages delivered, wraps
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | ready for a price; accept latches it into mem_wdata
// WRITE     | mem_we high for this single cycle
// SETTLE    | memory count updates; decide whether the window is full
// START     | ma_start high for this single cycle, wait counter cleared
// WAIT_DONE | waiting for ma_done, abort after TIMEOUT cycles
// OUTPUT    | avg_valid high for this single cycle, win_count bumps
module ma_window_scheduler #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 4,
  parameter int WINDOW  = 10,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_price,
  output logic              in_ready,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [CNT_W-1:0]  mem_count,
  input  logic              mem_full,
  output logic              ma_start,
  input  logic              ma_done,
  input  logic [DATA_W-1:0] ma_avg,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic              err_timeout,
  output logic [15:0]       win_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_START,
    S_WAIT_DONE,
    S_OUTPUT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       wait_last;
  logic       timeout_hit;
  logic       we_nxt;
  logic       start_nxt;
  logic       valid_nxt;

  // The counter holds the number of WAIT_DONE cycles already spent, so the
  // cycle in which it would reach TIMEOUT is the last one allowed.
  assign wait_last   = (wait_cnt == 8'(TIMEOUT - 1));
  assign timeout_hit = (state == S_WAIT_DONE) && !ma_done && wait_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (in_valid) state_nxt = S_WRITE;
      S_WRITE:     state_nxt = S_SETTLE;
      S_SETTLE:    state_nxt = mem_full ? S_START : S_IDLE;
      S_START:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // done wins over an expiring counter in the same cycle
        if (ma_done)        state_nxt = S_OUTPUT;
        else if (wait_last) state_nxt = S_IDLE;
      end
      S_OUTPUT:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are high exactly
  // during the state they belong to.
  always_comb begin
    in_ready  = (state == S_IDLE);
    we_nxt    = (state_nxt == S_WRITE);
    start_nxt = (state_nxt == S_START);
    valid_nxt = (state_nxt == S_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we      <= 1'b0;
      ma_start    <= 1'b0;
      avg_valid   <= 1'b0;
      mem_wdata   <= '0;
      avg_out     <= '0;
      err_timeout <= 1'b0;
      win_count   <= '0;
      wait_cnt    <= '0;
    end else begin
      mem_we    <= we_nxt;
      ma_start  <= start_nxt;
      avg_valid <= valid_nxt;
      if (state == S_IDLE && in_valid) mem_wdata <= in_price;
      if (state == S_START) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT_DONE && !ma_done) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (state == S_WAIT_DONE && ma_done) avg_out <= ma_avg;
      if (timeout_hit) err_timeout <= 1'b1;
      if (valid_nxt) win_count <= win_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (mem_count <= CNT_W'(WINDOW));
  end

endmodule

// File: doc/ma_window_scheduler.md
Name: ma_window_scheduler

Overview:
- Sequences the price-window datapath: accepts prices from an upstream feed on a valid/ready handshake and issues one-cycle write pulses into the 10-deep price memory.
- Once the memory reports full, starts the moving-average FSM after each write and waits for its done, with a timeout.
- Presents each result downstream as a one-cycle valid pulse.
- Sits between the market-data source and the memory + moving_average_fsm pair, replacing direct testbench drive of write_enable and start.

Parameters:
DATA_W, 32, price and average width
CNT_W, 4, width of memory fill count input
WINDOW, 10, window depth; must match memory depth
TIMEOUT, 63, max cycles to wait for ma_done before abort (1..2^8-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  upstream price valid
in_price  input  DATA_W  upstream price
in_ready  output  1  scheduler can accept a price
mem_we  output  1  write strobe to price memory, one cycle per accepted price
mem_wdata  output  DATA_W  price written to memory / presented to MA FSM
mem_count  input  CNT_W  memory fill count
mem_full  input  1  memory holds WINDOW prices
ma_start  output  1  one-cycle start pulse to moving-average FSM
ma_done  input  1  moving-average FSM completion
ma_avg  input  DATA_W  moving-average result
avg_valid  output  1  one-cycle pulse, avg_out valid
avg_out  output  DATA_W  latched moving average
err_timeout  output  1  sticky: an MA computation timed out
win_count  output  16  number of averages delivered, wraps at 2^16

Behaviour:
- Reset (rst=0 at a clock edge, in any state):
  - State -> IDLE.
  - mem_we=0, ma_start=0, avg_valid=0, avg_out=0, mem_wdata=0, err_timeout=0, win_count=0, wait counter=0.
  - in_ready goes to 1 in the first cycle after reset releases.
- FSM states: IDLE, WRITE, SETTLE, START, WAIT_DONE, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_price into mem_wdata; go to WRITE.
  - No accept: stay in IDLE.
- WRITE:
  - mem_we=1 for exactly this cycle; in_ready=0; go to SETTLE.
- SETTLE:
  - One cycle for the memory count to update.
  - mem_full=1: go to START. Else: go to IDLE.
- START:
  - ma_start=1 for exactly this cycle; clear wait counter; go to WAIT_DONE.
- WAIT_DONE:
  - ma_done=1: register ma_avg into avg_out; go to OUTPUT.
  - Else increment wait counter. When counter reaches TIMEOUT: set err_timeout, go to IDLE, no avg_valid.
  - ma_done takes priority if it arrives in the same cycle the counter reaches TIMEOUT.
- OUTPUT:
  - avg_valid=1 for one cycle; win_count increments (wraps); go to IDLE.
- in_ready is 1 only in IDLE. Prices are never dropped; upstream holds in_valid/in_price until accepted.
- Latency:
  - Accept edge -> mem_we high the next cycle.
  - Per-price cost: 3 cycles while filling; 5 + MA latency once full.
- ma_done outside WAIT_DONE is ignored. mem_wdata holds its value until the next accept.
- Outputs are registered, with no combinational path from input to output except in_ready, which is decoded from state.
- mem_count is used only for bench visibility and assertion: mem_count never exceeds WINDOW.
- err_timeout clears only on reset.

Test Plan:
1. Reset, then release; hold in_valid=0 for 5 cycles -> in_ready=1, all other outputs 0, no mem_we.
2. Fill: feed prices 1000,1005,...,1045 back-to-back with in_valid=1 -> exactly 10 mem_we pulses, 3 cycles apart, mem_wdata matching each price; ma_start first pulses 2 cycles after the 10th mem_we; avg_valid after ma_done with avg_out=1022; win_count=1.
3. Steady state: send 1050 with model ma_done 4 cycles after ma_start, ma_avg=1027 -> one mem_we, one ma_start, avg_valid with avg_out=1027, win_count=2; in_ready=0 from accept until return to IDLE.
4. Backpressure: in_valid held high with price 2000 while in WAIT_DONE -> no accept and no mem_we until IDLE; then 2000 is written exactly once.
5. Timeout: window full, ma_done never asserted -> after 63 WAIT_DONE cycles err_timeout=1 and stays 1, no avg_valid, in_ready=1 next cycle; a later good computation still produces avg_valid while err_timeout remains 1.
6. Reset mid-operation: assert rst=0 in WAIT_DONE and in WRITE -> next cycle all outputs at reset values, in_ready=1 after release; a stray ma_done in IDLE produces no avg_valid.
